// File: rtl/mining_word_sequencer_pkg.sv
// Shared definitions for the mining word sequencer: FSM command codes,
// internal state encoding and the SHA-256 small sigma functions.
package mining_word_sequencer_pkg;

  localparam logic [2:0] CMD_RESET   = 3'd0;
  localparam logic [2:0] CMD_IDLE    = 3'd1;
  localparam logic [2:0] CMD_START   = 3'd2;
  localparam logic [2:0] CMD_ISSUE   = 3'd3;
  localparam logic [2:0] CMD_ADVANCE = 3'd4;
  localparam logic [2:0] CMD_CODE5   = 3'd5;
  localparam logic [2:0] CMD_CODE6   = 3'd6;
  localparam logic [2:0] CMD_CODE7   = 3'd7;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_READY = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_msg_expand.sv
// Combinational SHA-256 message expansion: next schedule word from a
// 16-word sliding window (win[0] is the oldest word W[t-16]).
module sha256_msg_expand
  import mining_word_sequencer_pkg::*;
(
  input  logic [15:0][31:0] win,
  output logic [31:0]       new_word
);

  assign new_word = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

endmodule

// File: rtl/mining_word_sequencer.sv
// Loads a 15-word block header, then streams the message schedule W[t]
// for successive nonce attempts under control of an external mining FSM.
//
// Handshake: a header word is taken on every rising edge where
// ld_valid && ld_ready; ld_ready is high only while loading.
module mining_word_sequencer
  import mining_word_sequencer_pkg::*;
#(
  parameter int unsigned ROUNDS     = 64,
  parameter logic [31:0] NONCE_INIT = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  state,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        stopw,
  output logic        fine,
  output logic        round_en,
  output logic [5:0]  round_idx,
  output logic [31:0] w_word,
  output logic [31:0] nonce,
  output logic        nonce_wrap
);

  logic [1:0]        fsm_q, fsm_d;
  logic [3:0]        k_q, k_d;
  logic [5:0]        t_q, t_d;
  logic [31:0]       nonce_q, nonce_d;
  logic              wrap_q, wrap_d;
  logic              fine_q, fine_d;
  logic              round_en_q, round_en_d;
  logic [5:0]        round_idx_q, round_idx_d;
  logic [31:0]       w_word_q, w_word_d;
  logic [14:0][31:0] hdr_q, hdr_d;
  logic [15:0][31:0] win_q, win_d;
  logic [31:0]       new_word;
  logic [31:0]       nonce_inc;

  sha256_msg_expand u_expand (
    .win      (win_q),
    .new_word (new_word)
  );

  assign nonce_inc = nonce_q + 32'd1;

  always_comb begin
    fsm_d       = fsm_q;
    k_d         = k_q;
    t_d         = t_q;
    nonce_d     = nonce_q;
    wrap_d      = wrap_q;
    fine_d      = fine_q;
    round_en_d  = 1'b0;
    round_idx_d = round_idx_q;
    w_word_d    = w_word_q;
    hdr_d       = hdr_q;
    win_d       = win_q;

    // An abort command wins over everything, including a pending header word.
    if (state == CMD_RESET) begin
      fsm_d   = ST_LOAD;
      k_d     = 4'd0;
      t_d     = 6'd0;
      nonce_d = NONCE_INIT;
      fine_d  = 1'b0;
      wrap_d  = 1'b0;
    end else begin
      case (fsm_q)
        ST_LOAD: begin
          if (ld_valid) begin
            hdr_d[k_q] = ld_data;
            k_d        = k_q + 4'd1;
            if (k_q == 4'd14) fsm_d = ST_READY;
          end
        end
        ST_READY: begin
          if (state == CMD_START) begin
            win_d       = {nonce_q, hdr_q};
            t_d         = 6'd0;
            round_idx_d = 6'd0;
            fine_d      = 1'b0;
            fsm_d       = ST_RUN;
          end
        end
        ST_RUN: begin
          if (state == CMD_ISSUE) begin
            round_en_d  = 1'b1;
            round_idx_d = t_q;
            w_word_d    = win_q[0];
          end else if (state == CMD_ADVANCE) begin
            if (t_q == 6'(ROUNDS - 1)) begin
              fine_d = 1'b1;
              fsm_d  = ST_DONE;
            end else begin
              t_d   = t_q + 6'd1;
              win_d = {new_word, win_q[15:1]};
            end
          end
        end
        ST_DONE: begin
          if (state == CMD_START) begin
            nonce_d     = nonce_inc;
            wrap_d      = wrap_q | (nonce_q == 32'hFFFF_FFFF);
            win_d       = {nonce_inc, hdr_q};
            t_d         = 6'd0;
            round_idx_d = 6'd0;
            fine_d      = 1'b0;
            fsm_d       = ST_RUN;
          end
        end
        default: fsm_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q       <= ST_LOAD;
      k_q         <= 4'd0;
      t_q         <= 6'd0;
      nonce_q     <= NONCE_INIT;
      wrap_q      <= 1'b0;
      fine_q      <= 1'b0;
      round_en_q  <= 1'b0;
      round_idx_q <= 6'd0;
      w_word_q    <= 32'd0;
    end else begin
      fsm_q       <= fsm_d;
      k_q         <= k_d;
      t_q         <= t_d;
      nonce_q     <= nonce_d;
      wrap_q      <= wrap_d;
      fine_q      <= fine_d;
      round_en_q  <= round_en_d;
      round_idx_q <= round_idx_d;
      w_word_q    <= w_word_d;
    end
  end

  // Header buffer and window are pure datapath; their contents are only
  // consumed after a fresh load, so they carry no reset.
  always_ff @(posedge clock) begin
    hdr_q <= hdr_d;
    win_q <= win_d;
  end

  assign ld_ready   = (fsm_q == ST_LOAD);
  assign stopw      = (fsm_q == ST_READY);
  assign fine       = fine_q;
  assign round_en   = round_en_q;
  assign round_idx  = round_idx_q;
  assign w_word     = w_word_q;
  assign nonce      = nonce_q;
  assign nonce_wrap = wrap_q;

endmodule

// File: tb/tb_mining_word_sequencer.sv
// Randomized bench for mining_word_sequencer: a full SHA-256 schedule model
// feeds an expected queue that a negedge monitor drains on every round_en.
module tb_mining_word_sequencer;

  localparam int ROUNDS = 64;

  logic        clock;
  logic        reset;
  logic [2:0]  state;
  logic        ld_valid;
  logic [31:0] ld_data;

  logic        ld_ready, stopw, fine, round_en, nonce_wrap;
  logic [5:0]  round_idx;
  logic [31:0] w_word, nonce;

  logic        ld_ready_b, stopw_b, fine_b, round_en_b, nonce_wrap_b;
  logic [5:0]  round_idx_b;
  logic [31:0] w_word_b, nonce_b;

  mining_word_sequencer #(.ROUNDS(ROUNDS), .NONCE_INIT(32'h0000_0018)) dut (
    .clock(clock), .reset(reset), .state(state), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .stopw(stopw), .fine(fine), .round_en(round_en),
    .round_idx(round_idx), .w_word(w_word), .nonce(nonce), .nonce_wrap(nonce_wrap)
  );

  mining_word_sequencer #(.ROUNDS(ROUNDS), .NONCE_INIT(32'hFFFF_FFFF)) dut_b (
    .clock(clock), .reset(reset), .state(state), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready_b), .stopw(stopw_b), .fine(fine_b), .round_en(round_en_b),
    .round_idx(round_idx_b), .w_word(w_word_b), .nonce(nonce_b), .nonce_wrap(nonce_wrap_b)
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [37:0] exp_q[$];
  logic [31:0] m_hdr[15];
  logic [31:0] m_nonce;
  logic [31:0] sched[64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Reference model: straight SHA-256 schedule recurrence over a flat array.
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_sched();
    for (int t = 0; t < 15; t++) sched[t] = m_hdr[t];
    sched[15] = m_nonce;
    for (int t = 16; t < 64; t++)
      sched[t] = ref_s1(sched[t-2]) + sched[t-7] + ref_s0(sched[t-15]) + sched[t-16];
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (!reset && round_en) begin
      if (exp_q.size() == 0) begin
        chk("spurious_round_en", {31'd0, round_en}, 32'd0);
      end else begin
        logic [37:0] e;
        e = exp_q.pop_front();
        chk("round_idx", {26'd0, round_idx}, {26'd0, e[37:32]});
        chk("w_word", w_word, e[31:0]);
      end
    end
  end

  // Driver tasks
  function automatic logic [2:0] pick_code(input bit in_run);
    logic [2:0] other[6];
    logic [2:0] run_idle[5];
    other    = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    run_idle = '{3'd1, 3'd2, 3'd5, 3'd6, 3'd7};
    if (in_run) return run_idle[$urandom_range(0, 4)];
    return other[$urandom_range(0, 5)];
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_ld_ready"}, {31'd0, ld_ready}, 32'd1);
    chk({tag, "_stopw"}, {31'd0, stopw}, 32'd0);
    chk({tag, "_fine"}, {31'd0, fine}, 32'd0);
    chk({tag, "_round_en"}, {31'd0, round_en}, 32'd0);
    chk({tag, "_round_idx"}, {26'd0, round_idx}, 32'd0);
    chk({tag, "_w_word"}, w_word, 32'd0);
    chk({tag, "_nonce"}, nonce, 32'h18);
    chk({tag, "_nonce_wrap"}, {31'd0, nonce_wrap}, 32'd0);
    chk({tag, "_nonce_b"}, nonce_b, 32'hFFFF_FFFF);
  endtask

  task automatic load_header();
    for (int k = 0; k < 15; k++) begin
      repeat ($urandom_range(0, 2)) begin
        ld_valid = 1'b0;
        state    = pick_code(1'b0);
        step();
      end
      chk("ld_ready_load", {31'd0, ld_ready}, 32'd1);
      ld_valid = 1'b1;
      ld_data  = m_hdr[k];
      state    = 3'd1;
      step();
    end
    ld_valid = 1'b0;
    chk("stopw_ready", {31'd0, stopw}, 32'd1);
    chk("ld_ready_ready", {31'd0, ld_ready}, 32'd0);
    // Header words and round commands offered in READY must not disturb anything.
    ld_valid = 1'b1;
    ld_data  = $urandom;
    state    = 3'(3 + $urandom_range(0, 1));
    step();
    ld_valid = 1'b0;
    state    = 3'd1;
    chk("stopw_hold", {31'd0, stopw}, 32'd1);
  endtask

  task automatic run_attempt(input int n_rounds);
    state = 3'd2;
    step();
    chk("stopw_run", {31'd0, stopw}, 32'd0);
    chk("fine_cleared", {31'd0, fine}, 32'd0);
    chk("round_idx_restart", {26'd0, round_idx}, 32'd0);
    chk("nonce", nonce, m_nonce);
    build_sched();
    for (int t = 0; t < n_rounds; t++) begin
      if ($urandom_range(0, 3) != 0) begin
        exp_q.push_back({6'(t), sched[t]});
        state = 3'd3;
        step();
      end
      repeat ($urandom_range(0, 1)) begin
        state = pick_code(1'b1);
        step();
      end
      state = 3'd4;
      step();
      chk("fine", {31'd0, fine}, {31'd0, (t == ROUNDS - 1)});
    end
    state = 3'd1;
    chk("exp_q_drained", exp_q.size(), 32'd0);
  endtask

  task automatic done_hold();
    repeat (2) begin
      state = pick_code(1'b0);
      step();
      chk("fine_hold", {31'd0, fine}, 32'd1);
      chk("stopw_done", {31'd0, stopw}, 32'd0);
    end
    state = 3'd1;
  endtask

  task automatic random_header();
    for (int k = 0; k < 15; k++) m_hdr[k] = $urandom;
  endtask

  initial begin
    reset    = 1'b1;
    state    = 3'd1;
    ld_valid = 1'b0;
    ld_data  = 32'd0;
    m_nonce  = 32'h18;
    @(negedge clock);
    repeat (3) step();
    reset = 1'b0;
    check_reset_values("reset");

    // "abc" padded block, length word supplied as the nonce.
    m_hdr[0] = 32'h6162_6380;
    for (int k = 1; k < 15; k++) m_hdr[k] = 32'd0;
    load_header();
    run_attempt(ROUNDS);
    done_hold();

    m_nonce = m_nonce + 32'd1;
    run_attempt(ROUNDS);
    chk("nonce_b_wrapped", nonce_b, 32'd0);
    chk("nonce_wrap_b_set", {31'd0, nonce_wrap_b}, 32'd1);
    done_hold();
    chk("nonce_wrap_b_held", {31'd0, nonce_wrap_b}, 32'd1);
    chk("nonce_wrap_a_clear", {31'd0, nonce_wrap}, 32'd0);

    // Abort from DONE returns to LOAD with initial nonce and cleared flags.
    state = 3'd0;
    step();
    state   = 3'd1;
    m_nonce = 32'h18;
    chk("abort_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("abort_fine", {31'd0, fine}, 32'd0);
    chk("abort_nonce", nonce, 32'h18);
    chk("abort_nonce_b", nonce_b, 32'hFFFF_FFFF);
    chk("abort_wrap_b", {31'd0, nonce_wrap_b}, 32'd0);

    // Abort in READY together with ld_valid: the word must be dropped.
    random_header();
    load_header();
    state    = 3'd0;
    ld_valid = 1'b1;
    ld_data  = 32'hDEAD_BEEF;
    step();
    ld_valid = 1'b0;
    state    = 3'd1;
    chk("abort_ready_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("abort_ready_stopw", {31'd0, stopw}, 32'd0);
    chk("abort_ready_nonce", nonce, 32'h18);

    random_header();
    load_header();
    run_attempt(ROUNDS);
    done_hold();
    m_nonce = m_nonce + 32'd1;
    run_attempt($urandom_range(10, 40));

    // Reset in the middle of RUN.
    reset = 1'b1;
    state = 3'd3;
    step();
    check_reset_values("midrun_reset");
    reset   = 1'b0;
    state   = 3'd1;
    m_nonce = 32'h18;

    random_header();
    load_header();
    run_attempt(ROUNDS);
    done_hold();

    step();
    chk("exp_q_final", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
